// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and encodings for the pipelined control unit.
//   ctrl_t / CTRL_W  - control bundle carried through EX/MEM/WB
//   CTRL_BUBBLE      - all-zero bundle (no side effects)
//   CTRL_TRAP        - bundle injected on trap entry (writes trap PC to $k0)
//   PC_*             - next-PC select encodings
//   OP_* / F_*       - opcode and R-type funct values of the supported ISA
//   RD_* / M2R_*     - reg_dst and mem_to_reg codes
//   ALU_*            - alu_op codes
package pipe_ctrl_pkg;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] reg_dst;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_to_reg;
        logic       alu_src1;
        logic       alu_src2;
        logic       ext_op;
        logic       lu_op;
        logic       branch;
        logic [4:0] alu_op;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // reg_dst codes
    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RD = 2'd1;
    localparam logic [1:0] RD_RA = 2'd2;
    localparam logic [1:0] RD_K0 = 2'd3;

    // mem_to_reg codes
    localparam logic [1:0] M2R_ALU  = 2'd0;
    localparam logic [1:0] M2R_MEM  = 2'd1;
    localparam logic [1:0] M2R_PC4  = 2'd2;
    localparam logic [1:0] M2R_TRAP = 2'd3;

    // next-PC select
    localparam logic [2:0] PC_SEQ  = 3'b000;
    localparam logic [2:0] PC_JMP  = 3'b001;
    localparam logic [2:0] PC_JR   = 3'b010;
    localparam logic [2:0] PC_BR   = 3'b011;
    localparam logic [2:0] PC_HOLD = 3'b100;
    localparam logic [2:0] PC_UI   = 3'b101;
    localparam logic [2:0] PC_IRQ  = 3'b110;

    // opcodes
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    // REGIMM rt selecting bgez
    localparam logic [4:0] RT_BGEZ = 5'b00001;

    // R-type funct
    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_JALR = 6'h09;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    // alu_op codes
    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_ADDU = 5'd1;
    localparam logic [4:0] ALU_SUB  = 5'd2;
    localparam logic [4:0] ALU_SUBU = 5'd3;
    localparam logic [4:0] ALU_AND  = 5'd4;
    localparam logic [4:0] ALU_OR   = 5'd5;
    localparam logic [4:0] ALU_XOR  = 5'd6;
    localparam logic [4:0] ALU_NOR  = 5'd7;
    localparam logic [4:0] ALU_SLT  = 5'd8;
    localparam logic [4:0] ALU_SLTU = 5'd9;
    localparam logic [4:0] ALU_SLL  = 5'd10;
    localparam logic [4:0] ALU_SRL  = 5'd11;
    localparam logic [4:0] ALU_SRA  = 5'd12;
    localparam logic [4:0] ALU_LUI  = 5'd13;
    localparam logic [4:0] ALU_BEQ  = 5'd14;
    localparam logic [4:0] ALU_BNE  = 5'd15;
    localparam logic [4:0] ALU_BLEZ = 5'd16;
    localparam logic [4:0] ALU_BGTZ = 5'd17;
    localparam logic [4:0] ALU_BGEZ = 5'd18;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // reg_write, reg_dst=$k0, mem_to_reg=trap PC, everything else 0
    localparam ctrl_t CTRL_TRAP = '{1'b1, RD_K0, 1'b0, 1'b0, M2R_TRAP,
                                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};

endpackage

// File: rtl/pipe_ctrl_decode.sv
// pipe_ctrl_decode: purely combinational instruction decoder.
//   i_instr       in  32      instruction in ID
//   o_ctrl        out ctrl_t  decoded control bundle (bubble when undefined)
//   o_pc_src_dec  out 3       next-PC select implied by the instruction alone
//   o_undef       out 1       instruction is not part of the supported ISA
module pipe_ctrl_decode
    import pipe_ctrl_pkg::*;
(
    input  logic [31:0] i_instr,
    output ctrl_t       o_ctrl,
    output logic [2:0]  o_pc_src_dec,
    output logic        o_undef
);

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic [4:0] w_rt;
    logic       w_unused_bits;

    assign w_op    = i_instr[31:26];
    assign w_rt    = i_instr[20:16];
    assign w_funct = i_instr[5:0];
    // rs, rd, shamt and immediate are datapath concerns only
    assign w_unused_bits = ^{i_instr[25:21], i_instr[15:6]};

    always_comb begin
        o_ctrl       = CTRL_BUBBLE;
        o_pc_src_dec = PC_SEQ;
        o_undef      = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = RD_RD;
                case (w_funct)
                    F_ADD:  o_ctrl.alu_op = ALU_ADD;
                    F_ADDU: o_ctrl.alu_op = ALU_ADDU;
                    F_SUB:  o_ctrl.alu_op = ALU_SUB;
                    F_SUBU: o_ctrl.alu_op = ALU_SUBU;
                    F_AND:  o_ctrl.alu_op = ALU_AND;
                    F_OR:   o_ctrl.alu_op = ALU_OR;
                    F_XOR:  o_ctrl.alu_op = ALU_XOR;
                    F_NOR:  o_ctrl.alu_op = ALU_NOR;
                    F_SLT:  o_ctrl.alu_op = ALU_SLT;
                    F_SLTU: o_ctrl.alu_op = ALU_SLTU;
                    // shifts take shamt as operand A
                    F_SLL: begin o_ctrl.alu_src1 = 1'b1; o_ctrl.alu_op = ALU_SLL; end
                    F_SRL: begin o_ctrl.alu_src1 = 1'b1; o_ctrl.alu_op = ALU_SRL; end
                    F_SRA: begin o_ctrl.alu_src1 = 1'b1; o_ctrl.alu_op = ALU_SRA; end
                    F_JR: begin
                        o_ctrl       = CTRL_BUBBLE;
                        o_pc_src_dec = PC_JR;
                    end
                    F_JALR: begin
                        o_ctrl.mem_to_reg = M2R_PC4;
                        o_pc_src_dec      = PC_JMP;
                    end
                    default: begin
                        o_ctrl  = CTRL_BUBBLE;
                        o_undef = 1'b1;
                    end
                endcase
            end
            OP_REGIMM: begin
                if (w_rt == RT_BGEZ) begin
                    o_ctrl.branch = 1'b1;
                    o_ctrl.ext_op = 1'b1;
                    o_ctrl.alu_op = ALU_BGEZ;
                    o_pc_src_dec  = PC_BR;
                end else begin
                    o_undef = 1'b1;
                end
            end
            OP_J: o_pc_src_dec = PC_JMP;
            OP_JAL: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = RD_RA;
                o_ctrl.mem_to_reg = M2R_PC4;
                o_pc_src_dec      = PC_JMP;
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                o_ctrl.branch = 1'b1;
                o_ctrl.ext_op = 1'b1;
                o_pc_src_dec  = PC_BR;
                case (w_op)
                    OP_BEQ:  o_ctrl.alu_op = ALU_BEQ;
                    OP_BNE:  o_ctrl.alu_op = ALU_BNE;
                    OP_BLEZ: o_ctrl.alu_op = ALU_BLEZ;
                    default: o_ctrl.alu_op = ALU_BGTZ;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_src2  = 1'b1;
                o_ctrl.ext_op    = 1'b1;
                case (w_op)
                    OP_ADDI:  o_ctrl.alu_op = ALU_ADD;
                    OP_ADDIU: o_ctrl.alu_op = ALU_ADDU;
                    OP_SLTI:  o_ctrl.alu_op = ALU_SLT;
                    default:  o_ctrl.alu_op = ALU_SLTU;
                endcase
            end
            OP_ANDI: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_src2  = 1'b1;
                o_ctrl.alu_op    = ALU_AND;
            end
            OP_LUI: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_src2  = 1'b1;
                o_ctrl.lu_op     = 1'b1;
                o_ctrl.alu_op    = ALU_LUI;
            end
            OP_LW: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_read   = 1'b1;
                o_ctrl.mem_to_reg = M2R_MEM;
                o_ctrl.alu_src2   = 1'b1;
                o_ctrl.ext_op     = 1'b1;
                o_ctrl.alu_op     = ALU_ADD;
            end
            OP_SW: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.alu_src2  = 1'b1;
                o_ctrl.ext_op    = 1'b1;
                o_ctrl.alu_op    = ALU_ADD;
            end
            default: o_undef = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipelined control unit for the 5-stage MIPS core.
// Decodes the ID instruction, arbitrates branch flush / load-use stall /
// trap entry, and carries the control bundle through EX, MEM and WB.
// Optional feature macro: PIPE_CTRL_IRQ_EN (external interrupt traps,
// irq_ack, and interrupt masking while draining after a trap).
//   clk              in   1       core clock, rising edge
//   reset            in   1       asynchronous active-low reset
//   instr_id         in   32      instruction in ID
//   pc_kernel        in   1       PC[31] of the ID instruction (supervisor)
//   stall            in   1       load-use hazard request
//   branch_taken_ex  in   1       branch resolved taken in EX
//   irq / irq_mask   in   N_IRQ   level interrupt requests / enables
//   pc_src           out  3       next-PC select
//   flush_id         out  1       squash IF/ID
//   hold_id          out  1       hold PC and IF/ID
//   ui               out  1       undefined-instruction trap this cycle
//   irq_ack          out  N_IRQ   one-hot interrupt acknowledge
//   ex/mem/wb_ctrl   out  CTRL_W  registered stage bundles
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int N_IRQ        = 4,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr_id,
    input  logic              pc_kernel,
    input  logic              stall,
    input  logic              branch_taken_ex,
    input  logic [N_IRQ-1:0]  irq,
    input  logic [N_IRQ-1:0]  irq_mask,
    output logic [2:0]        pc_src,
    output logic              flush_id,
    output logic              hold_id,
    output logic              ui,
    output logic [N_IRQ-1:0]  irq_ack,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CTRL_W-1:0] mem_ctrl,
    output logic [CTRL_W-1:0] wb_ctrl
);

    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

    ctrl_t            w_dec_ctrl;
    logic [2:0]       w_dec_pc;
    logic             w_dec_undef;
    logic [N_IRQ-1:0] w_pend;
    logic [N_IRQ-1:0] w_irq_sel;
    ctrl_t            w_ex_next;
    state_t           w_state_nxt;
    logic [2:0]       w_cnt_nxt;

    state_t           r_state;
    logic [2:0]       r_cnt;
    ctrl_t            r_ex;
    ctrl_t            r_mem;
    ctrl_t            r_wb;

    pipe_ctrl_decode u_dec (
        .i_instr      (instr_id),
        .o_ctrl       (w_dec_ctrl),
        .o_pc_src_dec (w_dec_pc),
        .o_undef      (w_dec_undef)
    );

`ifdef PIPE_CTRL_IRQ_EN
    function automatic logic [N_IRQ-1:0] lowest_one(input logic [N_IRQ-1:0] v);
        lowest_one = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                lowest_one    = '0;
                lowest_one[i] = 1'b1;
            end
        end
    endfunction

    // Interrupts are eligible only in RUN, from user code, out of reset.
    assign w_pend    = (r_state == ST_RUN && !pc_kernel && reset) ? (irq & irq_mask) : '0;
    assign w_irq_sel = lowest_one(w_pend);
`else
    logic w_unused_irq;
    assign w_unused_irq = ^{irq, irq_mask};
    assign w_pend       = '0;
    assign w_irq_sel    = '0;
`endif

    always_comb begin
        pc_src      = w_dec_pc;
        flush_id    = 1'b0;
        hold_id     = 1'b0;
        ui          = 1'b0;
        irq_ack     = '0;
        w_ex_next   = w_dec_ctrl;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;

        // Drain progress; a stall below freezes it, a new trap reloads it.
        if (r_state == ST_DRAIN) begin
            if (r_cnt == 3'd0) begin
                w_state_nxt = ST_RUN;
            end else begin
                w_cnt_nxt = r_cnt - 3'd1;
            end
        end

        if (branch_taken_ex) begin
            pc_src    = PC_BR;
            flush_id  = 1'b1;
            w_ex_next = CTRL_BUBBLE;
        end else if (stall) begin
            pc_src      = PC_HOLD;
            hold_id     = 1'b1;
            w_ex_next   = CTRL_BUBBLE;
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
        end else if (w_dec_undef && !pc_kernel) begin
            pc_src      = PC_UI;
            flush_id    = 1'b1;
            ui          = 1'b1;
            w_ex_next   = CTRL_TRAP;
            w_state_nxt = ST_DRAIN;
            w_cnt_nxt   = DRAIN_LOAD;
        end else if (|w_pend) begin
            pc_src      = PC_IRQ;
            flush_id    = 1'b1;
            irq_ack     = w_irq_sel;
            w_ex_next   = CTRL_TRAP;
            w_state_nxt = ST_DRAIN;
            w_cnt_nxt   = DRAIN_LOAD;
        end else if (w_dec_undef) begin
            // supervisor code: undefined encodings execute as a nop
            pc_src    = PC_SEQ;
            w_ex_next = CTRL_BUBBLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_ex    <= CTRL_BUBBLE;
            r_mem   <= CTRL_BUBBLE;
            r_wb    <= CTRL_BUBBLE;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ex    <= w_ex_next;
            r_mem   <= r_ex;
            r_wb    <= r_mem;
        end
    end

    assign ex_ctrl  = r_ex;
    assign mem_ctrl = r_mem;
    assign wb_ctrl  = r_wb;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed, table-driven bench for pipe_ctrl, plus hand-written
// sequences for drain timing, branch/stall/interrupt priority and reset.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int NI = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       instr_id;
    logic              pc_kernel, stall, branch_taken_ex;
    logic [NI-1:0]     irq, irq_mask;
    logic [2:0]        pc_src;
    logic              flush_id, hold_id, ui;
    logic [NI-1:0]     irq_ack;
    logic [CTRL_W-1:0] ex_ctrl, mem_ctrl, wb_ctrl;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.N_IRQ(NI), .DRAIN_CYCLES(3)) dut (
        .clk(clk), .reset(reset), .instr_id(instr_id), .pc_kernel(pc_kernel),
        .stall(stall), .branch_taken_ex(branch_taken_ex), .irq(irq),
        .irq_mask(irq_mask), .pc_src(pc_src), .flush_id(flush_id),
        .hold_id(hold_id), .ui(ui), .irq_ack(irq_ack), .ex_ctrl(ex_ctrl),
        .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl)
    );

    typedef struct {
        logic [31:0] instr;
        logic        kern, stl, bt;
        logic [2:0]  pc;
        logic        fl, hd, u;
        ctrl_t       ex;
    } vec_t;

    vec_t tv[$];

    function automatic ctrl_t mk(input logic rw, input logic [1:0] rd,
                                 input logic mr, input logic mw, input logic [1:0] m2r,
                                 input logic s1, input logic s2, input logic ex,
                                 input logic lu, input logic br, input logic [4:0] op);
        mk = {rw, rd, mr, mw, m2r, s1, s2, ex, lu, br, op};
    endfunction

    task automatic addv(input logic [31:0] in, input logic k, input logic s, input logic b,
                        input logic [2:0] pc, input logic fl, input logic hd,
                        input logic u, input ctrl_t ex);
        vec_t v;
        v.instr = in; v.kern = k; v.stl = s; v.bt = b;
        v.pc = pc; v.fl = fl; v.hd = hd; v.u = u; v.ex = ex;
        tv.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] in, input logic k, input logic s, input logic b);
        instr_id = in; pc_kernel = k; stall = s; branch_taken_ex = b;
    endtask

    localparam logic [31:0] I_LW   = 32'h8D280000;
    localparam logic [31:0] I_ADD  = 32'h01095020;
    localparam logic [31:0] I_UNDF = 32'hFC000000;

    ctrl_t c_lw, c_add, c_trap, c_bub;
    ctrl_t h1, h2;
    logic [NI-1:0] exp_ack;
    logic [2:0]    exp_pc;

    initial begin
        c_bub  = '0;
        c_lw   = mk(1, 2'd0, 1, 0, 2'd1, 0, 1, 1, 0, 0, ALU_ADD);
        c_add  = mk(1, 2'd1, 0, 0, 2'd0, 0, 0, 0, 0, 0, ALU_ADD);
        c_trap = mk(1, 2'd3, 0, 0, 2'd3, 0, 0, 0, 0, 0, 5'd0);

        //    instr         k  s  b  pc      fl hd u  ex
        addv(I_LW,         0, 0, 0, 3'b000, 0, 0, 0, c_lw);
        addv(32'hAD280004, 0, 0, 0, 3'b000, 0, 0, 0, mk(0, 2'd0, 0, 1, 2'd0, 0, 1, 1, 0, 0, ALU_ADD));
        addv(I_ADD,        0, 0, 0, 3'b000, 0, 0, 0, c_add);
        addv(32'h3C081234, 0, 0, 0, 3'b000, 0, 0, 0, mk(1, 2'd0, 0, 0, 2'd0, 0, 1, 0, 1, 0, ALU_LUI));
        addv(32'h3108FFFF, 0, 0, 0, 3'b000, 0, 0, 0, mk(1, 2'd0, 0, 0, 2'd0, 0, 1, 0, 0, 0, ALU_AND));
        addv(32'h00094080, 0, 0, 0, 3'b000, 0, 0, 0, mk(1, 2'd1, 0, 0, 2'd0, 1, 0, 0, 0, 0, ALU_SLL));
        addv(32'h0C000010, 0, 0, 0, 3'b001, 0, 0, 0, mk(1, 2'd2, 0, 0, 2'd2, 0, 0, 0, 0, 0, ALU_ADD));
        addv(32'h03E00008, 0, 0, 0, 3'b010, 0, 0, 0, c_bub);
        addv(32'h11090004, 0, 0, 0, 3'b011, 0, 0, 0, mk(0, 2'd0, 0, 0, 2'd0, 0, 0, 1, 0, 1, ALU_BEQ));
        addv(32'h05010003, 0, 0, 0, 3'b011, 0, 0, 0, mk(0, 2'd0, 0, 0, 2'd0, 0, 0, 1, 0, 1, ALU_BGEZ));
        addv(32'h05000003, 0, 0, 0, 3'b101, 1, 0, 1, c_trap);
        addv(I_UNDF,       0, 0, 0, 3'b101, 1, 0, 1, c_trap);
        addv(I_UNDF,       1, 0, 0, 3'b000, 0, 0, 0, c_bub);
        addv(32'h0000000C, 0, 0, 0, 3'b101, 1, 0, 1, c_trap);
        addv(I_ADD,        0, 1, 0, 3'b100, 0, 1, 0, c_bub);
        addv(I_ADD,        0, 1, 0, 3'b100, 0, 1, 0, c_bub);
        addv(I_LW,         0, 1, 1, 3'b011, 1, 0, 0, c_bub);
        addv(32'h0100F809, 0, 0, 0, 3'b001, 0, 0, 0, mk(1, 2'd1, 0, 0, 2'd2, 0, 0, 0, 0, 0, ALU_ADD));
        addv(32'h2108FFFF, 0, 0, 0, 3'b000, 0, 0, 0, mk(1, 2'd0, 0, 0, 2'd0, 0, 1, 1, 0, 0, ALU_ADD));
        addv(32'h25080001, 0, 0, 0, 3'b000, 0, 0, 0, mk(1, 2'd0, 0, 0, 2'd0, 0, 1, 1, 0, 0, ALU_ADDU));
        addv(32'h2D08000A, 0, 0, 0, 3'b000, 0, 0, 0, mk(1, 2'd0, 0, 0, 2'd0, 0, 1, 1, 0, 0, ALU_SLTU));

        // Reset: bundles zero, combinational path alive, no acknowledge.
        reset = 1'b0;
        drive(I_LW, 0, 0, 0);
        irq = 4'b0110; irq_mask = 4'b1100;
        #3;
        chk("rst_ex", ex_ctrl, 0);
        chk("rst_mem", mem_ctrl, 0);
        chk("rst_wb", wb_ctrl, 0);
        chk("rst_pc", pc_src, 3'b000);
        chk("rst_ack", irq_ack, 0);
        cyc();
        chk("rst_ex_edge", ex_ctrl, 0);
        irq = '0;
        drive(I_UNDF, 1, 0, 0);
        reset = 1'b1;
        cyc(); cyc(); cyc();

        // Table: combinational outputs, then bundle progression EX->MEM->WB.
        h1 = '0; h2 = '0;
        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].instr, tv[i].kern, tv[i].stl, tv[i].bt);
            #1;
            chk($sformatf("v%0d_pc", i), pc_src, tv[i].pc);
            chk($sformatf("v%0d_flush", i), flush_id, tv[i].fl);
            chk($sformatf("v%0d_hold", i), hold_id, tv[i].hd);
            chk($sformatf("v%0d_ui", i), ui, tv[i].u);
            cyc();
            chk($sformatf("v%0d_ex", i), ex_ctrl, tv[i].ex);
            chk($sformatf("v%0d_mem", i), mem_ctrl, h1);
            chk($sformatf("v%0d_wb", i), wb_ctrl, h2);
            h2 = h1;
            h1 = tv[i].ex;
        end

        // lw bundle reaches WB three cycles after decode.
        drive(I_LW, 0, 0, 0);
        cyc();
        drive(I_UNDF, 1, 0, 0);
        cyc(); cyc();
        chk("lw_wb", wb_ctrl, c_lw);
        cyc(); cyc(); cyc(); cyc();

        // Interrupt accept, drain masking for 3 cycles, re-accept on cycle 4.
        drive(I_ADD, 0, 0, 0);
        irq = 4'b0110; irq_mask = 4'b1100;
        for (int k = 0; k < 5; k++) begin
`ifdef PIPE_CTRL_IRQ_EN
            exp_ack = (k == 0 || k == 4) ? 4'b0100 : 4'b0000;
`else
            exp_ack = 4'b0000;
`endif
            exp_pc = (exp_ack != 0) ? 3'b110 : 3'b000;
            #1;
            chk($sformatf("irq%0d_ack", k), irq_ack, exp_ack);
            chk($sformatf("irq%0d_pc", k), pc_src, exp_pc);
            cyc();
            chk($sformatf("irq%0d_ex", k), ex_ctrl, (exp_ack != 0) ? c_trap : c_add);
        end
        irq = '0;
        cyc(); cyc(); cyc(); cyc();

        // Branch beats stall beats interrupt; interrupt taken the next cycle.
        drive(I_ADD, 0, 1, 1);
        irq = 4'b0001; irq_mask = 4'b1111;
        #1;
        chk("bsi_pc", pc_src, 3'b011);
        chk("bsi_flush", flush_id, 1);
        chk("bsi_hold", hold_id, 0);
        chk("bsi_ack", irq_ack, 0);
        cyc();
        chk("bsi_ex", ex_ctrl, c_bub);
        drive(I_ADD, 0, 0, 0);
        #1;
`ifdef PIPE_CTRL_IRQ_EN
        chk("bsi_next_ack", irq_ack, 4'b0001);
        chk("bsi_next_pc", pc_src, 3'b110);
`else
        chk("bsi_next_ack", irq_ack, 4'b0000);
        chk("bsi_next_pc", pc_src, 3'b000);
`endif
        cyc();
        irq = '0;
        cyc(); cyc(); cyc(); cyc();

        // Reset asserted while draining after a UI trap.
        drive(I_UNDF, 0, 0, 0);
        cyc();
        chk("rd_trap_ex", ex_ctrl, c_trap);
        drive(I_ADD, 0, 0, 0);
        irq = 4'b0110; irq_mask = 4'b1100;
        #1;
        chk("rd_drain_ack", irq_ack, 0);
        #1;
        reset = 1'b0;
        #1;
        chk("rd_ex", ex_ctrl, 0);
        chk("rd_mem", mem_ctrl, 0);
        chk("rd_wb", wb_ctrl, 0);
        chk("rd_ack", irq_ack, 0);
        cyc(); cyc();
        reset = 1'b1;
        #1;
`ifdef PIPE_CTRL_IRQ_EN
        chk("rd_rel_ack", irq_ack, 4'b0100);
        chk("rd_rel_pc", pc_src, 3'b110);
`else
        chk("rd_rel_ack", irq_ack, 4'b0000);
        chk("rd_rel_pc", pc_src, 3'b000);
`endif
        cyc();
`ifdef PIPE_CTRL_IRQ_EN
        chk("rd_rel_ex", ex_ctrl, c_trap);
`else
        chk("rd_rel_ex", ex_ctrl, c_add);
`endif
        chk("rd_rel_mem", mem_ctrl, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipelined control unit for the 5-stage MIPS core. It decodes the ID-stage instruction into a control bundle and carries that bundle through registered EX/MEM/WB copies. It also sequences pipeline stalls, branch flushes and traps (undefined instruction, masked external interrupts) through a small FSM. It sits between the IF/ID register and the datapath, and replaces the flat combinational decoder.

## Interface
Parameters:
- N_IRQ, 4: number of external interrupt lines (1..8).
- DRAIN_CYCLES, 3: cycles after a trap during which new interrupts are not accepted (1..7).

Ports (clock and reset first):
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr_id  in  32  instruction in ID.
- pc_kernel  in  1  PC[31] of the ID instruction; 1 means supervisor mode.
- stall  in  1  load-use hazard request from the hazard unit.
- branch_taken_ex  in  1  branch resolved taken in EX.
- irq  in  N_IRQ  level-sensitive interrupt requests.
- irq_mask  in  N_IRQ  1 enables the corresponding line.
- pc_src  out  3  next-PC select (see package encodings).
- flush_id  out  1  squash the IF/ID register.
- hold_id  out  1  hold PC and IF/ID.
- ui  out  1  undefined-instruction trap taken this cycle.
- irq_ack  out  N_IRQ  one-hot; pulses for one cycle on interrupt trap entry.
- ex_ctrl  out  CTRL_W  registered EX bundle.
- mem_ctrl  out  CTRL_W  registered MEM bundle.
- wb_ctrl  out  CTRL_W  registered WB bundle.

## Operation
- The decode covers the existing ISA: lw, sw, lui, addi, addiu, andi, slti, sltiu, beq, bne, blez, bgtz, bgez, j, jal, and R-type add…sltu, sll/srl/sra, jr, jalr.
  - Any other opcode or funct is undefined (UI).
  - bgez is recognised only when rt==5'b00001.
- Bundle fields:
  - reg_write, reg_dst[1:0] (0 rt, 1 rd, 2 $ra, 3 $k0)
  - mem_read, mem_write
  - mem_to_reg[1:0] (0 ALU, 1 mem, 2 PC+4, 3 trap PC)
  - alu_src1, alu_src2, ext_op, lu_op, branch, alu_op[4:0]
  - The all-zero bundle is the bubble.
- pc_src priority, highest first:
  1. branch_taken_ex → 011, flush_id=1, ex_ctrl←bubble.
  2. stall → 100, hold_id=1, ex_ctrl←bubble.
  3. Trap → 101 (UI) or 110 (IRQ), flush_id=1, ex_ctrl←trap bundle.
  4. Decode → 000 sequential, 001 j/jal/jalr, 010 jr, 011 conditional branch.
- mem_ctrl←ex_ctrl and wb_ctrl←mem_ctrl every cycle, including during stall.
- Trap conditions (state RUN, no branch_taken_ex, no stall):
  - UI: the ID instruction is undefined and pc_kernel=0. UI has priority over IRQ.
  - IRQ: (irq & irq_mask)≠0 and pc_kernel=0. The lowest-index pending line wins and receives irq_ack.
  - Trap bundle: reg_write=1, reg_dst=3, mem_to_reg=3; all other fields 0.
  - Undefined instruction with pc_kernel=1: treated as a nop (pc_src 000, bubble).
- FSM:
  - RUN → DRAIN on trap entry; the counter loads DRAIN_CYCLES-1.
  - DRAIN: IRQ is ignored, but UI is still taken. Decrements each cycle that is not a stall, and returns to RUN when the counter reaches 0.
  - A UI taken in DRAIN reloads the counter.

## Timing
- pc_src, flush_id, hold_id, ui and irq_ack are combinational from the ID inputs and current state; they are valid in the same cycle.
- Bundles take one cycle per stage: decode in cycle n appears on ex_ctrl at n+1, mem_ctrl at n+2, wb_ctrl at n+3.
- Reset (asynchronous, while low):
  - ex_ctrl, mem_ctrl and wb_ctrl are 0.
  - State is RUN and the counter is 0.
  - Combinational outputs follow the inputs, with irq_ack=0.
- Reset asserted mid-DRAIN returns the FSM to RUN immediately.
- branch_taken_ex together with a pending IRQ: the IRQ is deferred to the next eligible cycle. Level-sensitive lines are retained by the source.

## Configuration
- PIPE_CTRL_IRQ_EN defined: interrupt logic, irq_ack and the DRAIN IRQ masking are present.
- PIPE_CTRL_IRQ_EN undefined:
  - irq and irq_mask are ignored, and irq_ack is tied to 0.
  - pc_src never takes the value 110.
  - DRAIN is still used after a UI trap.

## Structure
- Package pipe_ctrl_pkg holds:
  - the ctrl_t packed struct and CTRL_W
  - the bubble constant
  - PC_SEQ/PC_JMP/PC_JR/PC_BR/PC_HOLD/PC_UI/PC_IRQ encodings
  - opcode and funct localparams
  - reg_dst/mem_to_reg codes
- Sub-module pipe_ctrl_decode: purely combinational instr→{ctrl_t, pc_src_dec, undef}. pipe_ctrl holds the FSM, arbitration and stage registers.

## Test plan
- lw $t0,0($t1) (0x8D280000) with no stall → pc_src 000; ex_ctrl next cycle has mem_read=1, alu_src2=1, mem_to_reg=1, reg_dst=0; the same bundle is on wb_ctrl 3 cycles after decode.
- stall=1 for 2 cycles with add in ID → pc_src 100 and hold_id=1 both cycles; ex_ctrl is bubble; mem_ctrl/wb_ctrl keep advancing.
- 0xFC000000 with pc_kernel=0 → pc_src 101, ui=1, flush_id=1; ex_ctrl = trap bundle (reg_dst=3, mem_to_reg=3). The same instruction with pc_kernel=1 → pc_src 000, bubble.
- irq=4'b0110, irq_mask=4'b1100, pc_kernel=0 → pc_src 110, irq_ack=4'b0100; irq held high for the next DRAIN_CYCLES=3 cycles → no further ack; the ack repeats on cycle 4.
- branch_taken_ex=1 with stall=1 and an unmasked IRQ → pc_src 011, flush_id=1, irq_ack=0; the IRQ is taken the next cycle.
- Reset low during DRAIN → bundles 0 and state RUN; after release, a pending IRQ is acknowledged on the first eligible edge.
